// File: rtl/vga_stream_capture.sv
// VGA receive front end: recovers pixel coordinates from hsync/vsync edges,
// verifies line/frame lengths and strobes each active pixel once locked.
module vga_stream_capture #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_ACT = 0
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       pix_en,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [7:0] rgb,
  output logic       px_valid,
  output logic [9:0] px_x,
  output logic [8:0] px_y,
  output logic [7:0] px_data,
  output logic       frame_start,
  output logic       frame_done,
  output logic       locked,
  output logic       err_hlen,
  output logic       err_vlen
);
  localparam int   H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int   H_OFF   = H_SYNC + H_BP;
  localparam int   V_OFF   = V_SYNC + V_BP;
  localparam logic SACT    = 1'(SYNC_ACT);

  typedef enum logic [1:0] {SEARCH, SYNCING, LOCKED} state_t;
  state_t state, state_nx;

  logic       hs_prev, vs_prev, h_seen, v_seen, v_pend, ferr, ferr_nx;
  logic [9:0] hpos, line, hpos_cur, line_cur, xoff, yoff;
  logic       hs_lead, vs_lead, eh, ev, active, pv;

  // prev-sample flags hold "was active", so reset value 0 means inactive
  assign hs_lead = pix_en & (hsync == SACT) & ~hs_prev;
  assign vs_lead = pix_en & (vsync == SACT) & ~vs_prev;

  assign hpos_cur = hs_lead ? 10'd0 : ((hpos == 10'h3ff) ? hpos : hpos + 10'd1);

  always_comb begin
    line_cur = line;
    if (hs_lead)
      line_cur = (v_pend | vs_lead) ? 10'd0 : ((line == 10'h3ff) ? line : line + 10'd1);
  end

  // hpos/line still hold the prior sample's values when the edge is seen
  assign eh = hs_lead & h_seen & (hpos != 10'(H_TOTAL - 1));
  assign ev = vs_lead & v_seen & (line != 10'(V_TOTAL - 1));

  assign xoff   = hpos_cur - 10'(H_OFF);
  assign yoff   = line_cur - 10'(V_OFF);
  assign active = (hpos_cur >= 10'(H_OFF)) && (hpos_cur < 10'(H_OFF + H_ACTIVE)) &&
                  (line_cur >= 10'(V_OFF)) && (line_cur < 10'(V_OFF + V_ACTIVE));

  always_comb begin
    state_nx = state;
    ferr_nx  = ferr;
    if (pix_en) begin
      case (state)
        SEARCH: if (vs_lead) begin
          state_nx = SYNCING;
          ferr_nx  = 1'b0;
        end
        SYNCING: begin
          if (eh) ferr_nx = 1'b1;
          if (vs_lead) begin
            if (!ev && !ferr && !eh) state_nx = LOCKED;
            ferr_nx = 1'b0;
          end
        end
        LOCKED: if (eh || ev) begin
          state_nx = SYNCING;
          ferr_nx  = 1'b0;
        end
        default: state_nx = SEARCH;
      endcase
    end
  end

  assign pv     = pix_en & (state == LOCKED) & (state_nx == LOCKED) & active;
  assign locked = (state == LOCKED);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SEARCH;
      ferr    <= 1'b0;
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
      h_seen  <= 1'b0;
      v_seen  <= 1'b0;
      v_pend  <= 1'b0;
      hpos    <= '0;
      line    <= '0;
    end else if (pix_en) begin
      state   <= state_nx;
      ferr    <= ferr_nx;
      hs_prev <= (hsync == SACT);
      vs_prev <= (vsync == SACT);
      h_seen  <= h_seen | hs_lead;
      v_seen  <= v_seen | vs_lead;
      v_pend  <= hs_lead ? 1'b0 : (v_pend | vs_lead);
      hpos    <= hpos_cur;
      line    <= line_cur;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      px_valid    <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      err_hlen    <= 1'b0;
      err_vlen    <= 1'b0;
      px_x        <= '0;
      px_y        <= '0;
      px_data     <= '0;
    end else begin
      px_valid    <= pv;
      frame_start <= pv && (xoff == 10'd0) && (yoff == 10'd0);
      frame_done  <= pv && (xoff == 10'(H_ACTIVE - 1)) && (yoff == 10'(V_ACTIVE - 1));
      err_hlen    <= eh;
      err_vlen    <= ev;
      if (pv) begin
        px_x    <= xoff;
        px_y    <= yoff[8:0];
        px_data <= rgb;
      end
    end
  end
endmodule

// File: tb/tb_vga_stream_capture.sv
// Randomized-gap bench for vga_stream_capture on a shrunken raster, checked
// against a sample-by-sample reference model of the sync/lock rules.
module tb_vga_stream_capture;
  localparam int HA = 8, HF = 2, HS = 3, HB = 2, VA = 6, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB;
  localparam int HO = HS + HB, VO = VS + VB;
  localparam bit SACT = 1'b0;

  logic clk_in = 0, rst_n = 0, pix_en = 0, hsync = ~SACT, vsync = ~SACT;
  logic [7:0] rgb = 0;
  logic px_valid, frame_start, frame_done, locked, err_hlen, err_vlen;
  logic [9:0] px_x;
  logic [8:0] px_y;
  logic [7:0] px_data;

  vga_stream_capture #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_ACT(0)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
    .rgb(rgb), .px_valid(px_valid), .px_x(px_x), .px_y(px_y), .px_data(px_data),
    .frame_start(frame_start), .frame_done(frame_done), .locked(locked),
    .err_hlen(err_hlen), .err_vlen(err_vlen));

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [31:0] cyc;
    logic pv; logic [9:0] x; logic [8:0] y; logic [7:0] d;
    logic fs, fd, lk, eh, ev;
  } ev_t;

  ev_t dut_q[$], exp_q[$];
  int errors = 0, checks = 0;
  int cyc = 0, last_out_cyc = 0, line_first_cyc = 0, frame_cyc = 0;
  int lc[0:15];
  int n_pv = 0, n_eh = 0, n_ev = 0, n_fs = 0, n_fd = 0;
  int rise_cyc = -1, fall_cyc = -1, last_pv_cyc = -1;
  logic [18:0] fs_xy = '1, fd_xy = '1;
  logic mon_lk = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Record every cycle where the DUT pulses something or changes lock.
  always @(negedge clk_in) begin
    if (!rst_n) mon_lk <= 1'b0;
    else if (px_valid || err_hlen || err_vlen || frame_start || frame_done || locked != mon_lk) begin
      dut_q.push_back('{cyc: cyc, pv: px_valid, x: px_valid ? px_x : 10'd0,
                        y: px_valid ? px_y : 9'd0, d: px_valid ? px_data : 8'd0,
                        fs: frame_start, fd: frame_done, lk: locked, eh: err_hlen, ev: err_vlen});
      mon_lk <= locked;
      if (px_valid) begin n_pv <= n_pv + 1; last_pv_cyc <= cyc; end
      if (err_hlen) n_eh <= n_eh + 1;
      if (err_vlen) n_ev <= n_ev + 1;
      if (frame_start) begin n_fs <= n_fs + 1; fs_xy <= {px_x, px_y}; end
      if (frame_done) begin n_fd <= n_fd + 1; fd_xy <= {px_x, px_y}; end
      if (locked && !mon_lk) rise_cyc <= cyc;
      if (!locked && mon_lk) fall_cyc <= cyc;
    end
  end

  // Reference model: 0 = hunting, 1 = verifying a frame, 2 = delivering pixels
  bit m_hprev, m_vprev, m_hseen, m_vseen, m_vpend, m_ferr, m_lk;
  int m_pos, m_line, m_st, m_lastx, m_lasty;

  task automatic model_reset();
    {m_hprev, m_vprev, m_hseen, m_vseen, m_vpend, m_ferr, m_lk} = '0;
    m_pos = 0; m_line = 0; m_st = 0;
  endtask

  task automatic model_step(bit hs, bit vs, logic [7:0] d, int c);
    bit hl, vl, eh, ev, pv;
    int pos, ln, nst;
    hl = hs && !m_hprev;
    vl = vs && !m_vprev;
    pos = hl ? 0 : (m_pos < 1023 ? m_pos + 1 : 1023);
    ln = m_line;
    if (hl) ln = (m_vpend || vl) ? 0 : (m_line < 1023 ? m_line + 1 : 1023);
    eh = hl && m_hseen && (m_pos != HT - 1);
    ev = vl && m_vseen && (m_line != VT - 1);
    nst = m_st;
    case (m_st)
      0: if (vl) begin nst = 1; m_ferr = 0; end
      1: begin
        if (eh) m_ferr = 1;
        if (vl) begin if (!ev && !m_ferr) nst = 2; m_ferr = 0; end
      end
      default: if (eh || ev) begin nst = 1; m_ferr = 0; end
    endcase
    pv = (m_st == 2) && (nst == 2) && pos >= HO && pos < HO + HA && ln >= VO && ln < VO + VA;
    if (pv || eh || ev || ((nst == 2) != m_lk)) begin
      exp_q.push_back('{cyc: c, pv: pv, x: pv ? 10'(pos - HO) : 10'd0, y: pv ? 9'(ln - VO) : 9'd0,
                        d: pv ? d : 8'd0, fs: pv && pos == HO && ln == VO,
                        fd: pv && pos == HO + HA - 1 && ln == VO + VA - 1,
                        lk: nst == 2, eh: eh, ev: ev});
    end
    if (pv) begin m_lastx = pos - HO; m_lasty = ln - VO; end
    m_lk = (nst == 2); m_st = nst;
    m_hprev = hs; m_vprev = vs;
    m_hseen |= hl; m_vseen |= vl;
    m_vpend = hl ? 1'b0 : (m_vpend | vl);
    m_pos = pos; m_line = ln;
  endtask

  task automatic send(bit hs, bit vs, logic [7:0] d);
    @(posedge clk_in); #1;
    hsync = hs ? SACT : ~SACT;
    vsync = vs ? SACT : ~SACT;
    rgb = d; pix_en = 1'b1;
    last_out_cyc = cyc + 1;
    model_step(hs, vs, d, cyc + 1);
    @(posedge clk_in); #1;
    pix_en = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge clk_in);
  endtask

  task automatic send_line(int len, bit vs, int from, int to);
    for (int i = from; i < to && i < len; i++) begin
      send(i < HS, vs, 8'($urandom));
      if (i == from) line_first_cyc = last_out_cyc;
    end
  endtask

  task automatic send_frame(int nl, int short_l, int stop_l);
    for (int l = 0; l < nl; l++) begin
      if (l == stop_l) return;
      send_line((l == short_l) ? HT - 1 : HT, l < VS, 0, HT);
      if (l < 16) lc[l] = line_first_cyc;
      if (l == 0) frame_cyc = line_first_cyc;
    end
  endtask

  task automatic do_reset();
    @(posedge clk_in); #1;
    rst_n = 0; pix_en = 0; hsync = ~SACT; vsync = ~SACT;
    repeat (2) @(posedge clk_in);
    #1 rst_n = 1;
    model_reset();
  endtask

  task automatic test_reset();
    int pv0;
    rst_n = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk_in); #1;
      hsync = 1'($urandom_range(0, 1)); vsync = 1'($urandom_range(0, 1));
      pix_en = 1'($urandom_range(0, 1)); rgb = 8'($urandom);
      @(negedge clk_in);
      checks++;
      if ({px_valid, px_x, px_y, px_data, frame_start, frame_done, locked, err_hlen, err_vlen} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got %b required all zero",
          {px_valid, px_x, px_y, px_data, frame_start, frame_done, locked, err_hlen, err_vlen});
      end
    end
    do_reset();
    pv0 = n_pv;
    send_frame(VT, -1, -1);
    repeat (2) @(posedge clk_in); #1;
    checks++;
    if (n_pv != pv0 || locked !== 1'b0) begin
      errors++; $display("FAIL reset_no_pv: pv=%0d locked=%b required pv=0 locked=0", n_pv - pv0, locked);
    end
  endtask

  task automatic test_nominal_lock();
    int pv0, fs0, fd0;
    do_reset();
    send_frame(VT, -1, -1);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL lock_early: locked=%b required 0", locked); end
    send_frame(VT, -1, -1);
    checks++;
    if (rise_cyc != frame_cyc) begin
      errors++; $display("FAIL lock_rise: cycle %0d required %0d", rise_cyc, frame_cyc);
    end
    pv0 = n_pv; fs0 = n_fs; fd0 = n_fd;
    send_frame(VT, -1, -1);
    repeat (2) @(posedge clk_in); #1;
    checks++;
    if (n_pv - pv0 != HA * VA) begin
      errors++; $display("FAIL frame_pixels: got %0d required %0d", n_pv - pv0, HA * VA);
    end
    checks++;
    if (n_fs - fs0 != 1 || n_fd - fd0 != 1) begin
      errors++; $display("FAIL frame_pulses: fs=%0d fd=%0d required 1 1", n_fs - fs0, n_fd - fd0);
    end
    checks++;
    if (fs_xy !== {10'd0, 9'd0}) begin errors++; $display("FAIL fs_coord: got %h required 0", fs_xy); end
    checks++;
    if (fd_xy !== {10'(HA - 1), 9'(VA - 1)}) begin
      errors++; $display("FAIL fd_coord: got %h required %h", fd_xy, {10'(HA - 1), 9'(VA - 1)});
    end
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL locked_hold: locked=%b required 1", locked); end
  endtask

  task automatic test_short_line();
    int eh0;
    eh0 = n_eh;
    send_frame(VT, 6, -1);
    repeat (2) @(posedge clk_in); #1;
    checks++;
    if (n_eh - eh0 != 1) begin errors++; $display("FAIL short_eh: got %0d pulses required 1", n_eh - eh0); end
    checks++;
    if (fall_cyc != lc[7]) begin errors++; $display("FAIL short_fall: cycle %0d required %0d", fall_cyc, lc[7]); end
    checks++;
    if (last_pv_cyc >= fall_cyc || locked !== 1'b0) begin
      errors++; $display("FAIL short_nopv: last pv %0d fall %0d locked=%b required pv before fall, unlocked",
        last_pv_cyc, fall_cyc, locked);
    end
    send_frame(VT, -1, -1);
    checks++;
    if (rise_cyc != frame_cyc || locked !== 1'b1) begin
      errors++; $display("FAIL short_relock: cycle %0d locked=%b required %0d locked=1", rise_cyc, locked, frame_cyc);
    end
  endtask

  task automatic test_long_frame();
    int ev0;
    ev0 = n_ev;
    send_frame(VT + 1, -1, -1);
    send_frame(VT, -1, -1);
    checks++;
    if (n_ev - ev0 != 1 || fall_cyc != frame_cyc) begin
      errors++; $display("FAIL long_ev: pulses %0d fall %0d required 1 at %0d", n_ev - ev0, fall_cyc, frame_cyc);
    end
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL long_unlock: locked=%b required 0", locked); end
    send_frame(VT, -1, -1);
    checks++;
    if (rise_cyc != frame_cyc || locked !== 1'b1) begin
      errors++; $display("FAIL long_relock: cycle %0d locked=%b required %0d locked=1", rise_cyc, locked, frame_cyc);
    end
  endtask

  task automatic test_reset_mid();
    send_frame(VT, -1, 7);
    send_line(HT, 1'b0, 0, 7);
    @(posedge clk_in); #1 rst_n = 0;
    @(negedge clk_in);
    checks++;
    if ({px_valid, frame_start, frame_done, locked, err_hlen, err_vlen, px_x, px_y, px_data} !== '0) begin
      errors++; $display("FAIL midreset_out: locked=%b px_x=%0d required all zero", locked, px_x);
    end
    repeat (3) @(posedge clk_in);
    #1 rst_n = 1;
    model_reset();
    send_frame(VT, -1, -1);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL midreset_early: locked=%b required 0", locked); end
    send_frame(VT, -1, -1);
    checks++;
    if (rise_cyc != frame_cyc) begin
      errors++; $display("FAIL midreset_relock: cycle %0d required %0d", rise_cyc, frame_cyc);
    end
  endtask

  task automatic test_stall();
    int pv0, idx;
    send_frame(VT, -1, VO + 1);
    send_line(HT, 1'b0, 0, HO + 3);
    repeat (2) @(posedge clk_in);
    pv0 = n_pv;
    repeat (1000) @(posedge clk_in);
    @(negedge clk_in); #1;
    checks++;
    if (n_pv != pv0) begin errors++; $display("FAIL stall_pv: got %0d strobes required 0", n_pv - pv0); end
    checks++;
    if (px_x !== 10'(m_lastx) || px_y !== 9'(m_lasty) || locked !== 1'b1) begin
      errors++; $display("FAIL stall_hold: x=%0d y=%0d locked=%b required x=%0d y=%0d locked=1",
        px_x, px_y, locked, m_lastx, m_lasty);
    end
    idx = dut_q.size();
    send_line(HT, 1'b0, HO + 3, HT);
    for (int l = VO + 2; l < VT; l++) send_line(HT, 1'b0, 0, HT);
    repeat (2) @(posedge clk_in); #1;
    checks++;
    if (n_pv - pv0 != (HA - 3) + HA * (VA - 2)) begin
      errors++; $display("FAIL stall_resume_cnt: got %0d required %0d", n_pv - pv0, (HA - 3) + HA * (VA - 2));
    end
    checks++;
    if (dut_q.size() <= idx || dut_q[idx].x !== 10'd3 || dut_q[idx].y !== 9'd1 || dut_q[idx].pv !== 1'b1) begin
      errors++; $display("FAIL stall_resume_xy: first strobe after stall not (3,1)");
    end
  endtask

  task automatic test_trace();
    checks++;
    if (dut_q.size() != exp_q.size()) begin
      errors++; $display("FAIL trace_len: got %0d events required %0d", dut_q.size(), exp_q.size());
    end
    for (int i = 0; i < dut_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (dut_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL trace[%0d]: got %h required %h", i, dut_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_nominal_lock();
    test_short_line();
    test_long_frame();
    test_reset_mid();
    test_stall();
    test_trace();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule
